addsub_bist: RTL and testbench
==============================

// Module: addsub_bist
// PURPOSE
//   On-chip self-test engine for the 4-bit add/subtract unit: drives select/a/b into the
//   unit and reads back its result. Compares each result against an internal golden model.
//   Reports error count, first failing vector and pass/fail.
//   Sits beside the add/sub unit; its outputs replace bench stimulus in silicon bring-up.
// PARAMETERS
//   WIDTH   4  operand/result width; arithmetic is mod 2^WIDTH
//   MAX_OP  7  highest operand value swept (MAX_OP < 2^WIDTH)
//   SETTLE  1  cycles (>=1) operands are held before the result is sampled
//   ERR_W   8  width of error counter
// PORTS
//   clk         in   1      clock, all state on rising edge
//   rst_n       in   1      reset, asynchronous, active-low
//   start       in   1      level-sampled request to run the sweep
//   select_o    out  2      op to unit: 2'b00 add, 2'b01 subtract (2'b1x never driven)
//   a_o         out  WIDTH  operand a to unit
//   b_o         out  WIDTH  operand b to unit
//   o_i         in   WIDTH  result from unit
//   busy        out  1      sweep in progress
//   done        out  1      sweep finished; held until next accepted start
//   pass        out  1      done && err_count==0
//   err_count   out  ERR_W  mismatches this run, saturates at all-ones
//   fail_valid  out  1      at least one mismatch captured
//   fail_sel    out  2      select of first mismatch
//   fail_a      out  WIDTH  a of first mismatch
//   fail_b      out  WIDTH  b of first mismatch
//   fail_got    out  WIDTH  o_i of first mismatch
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE; all outputs 0, including select_o/a_o/b_o.
//   States: IDLE, WAIT, CHECK, DONE.
//   IDLE/DONE + start=1: next edge clears err_count, fail_*, done and pass; sets busy.
//     It loads vector 0 (sel=0,a=0,b=0) and enters WAIT.
//   WAIT: holds operands for SETTLE cycles (counter), then goes to CHECK.
//   CHECK (1 cycle): at the closing edge, compares o_i with expected computed from registered operands.
//     Expected: add (a+b) mod 2^WIDTH; subtract (a-b) mod 2^WIDTH.
//     On mismatch, err_count+1 (saturating); if fail_valid=0, capture fail_* and set fail_valid.
//     Same edge: loads the next vector and returns to WAIT, or goes to DONE after the last vector.
//   Vector order:
//     add phase: sel=0, a=0..MAX_OP outer, b=0..MAX_OP inner.
//     sub phase: sel=1, a=1..MAX_OP outer, b=0..a-1 inner (no underflow vectors).
//   Vector count N = (MAX_OP+1)^2 + MAX_OP*(MAX_OP+1)/2; defaults give 64+28=92.
//   Vector period = SETTLE+1 cycles; done rises N*(SETTLE+1) edges after the loading edge.
//     Defaults: 184.
//   DONE: busy=0, done=1, pass per err_count; operands hold last vector.
//   start while busy: ignored, no restart.
//   start held high through DONE: sweep restarts on the next edge.
//   Reset mid-run: immediate abort to IDLE with all outputs 0; no partial results kept.
// TESTING
//   1 Ideal add/sub model on o_i, start pulse -> done after 184 cycles.
//     Expect err_count=0, pass=1, fail_valid=0.
//   2 o_i bit0 stuck at 0 -> err_count=48, pass=0.
//     First failure: fail_sel=0, a=0, b=1, got=0.
//   3 Model always adds -> err_count=21.
//     First failure: fail_sel=1, a=2, b=1, got=3.
//   4 rst_n low at cycle 50 mid-sweep -> all outputs 0 at once.
//     A fresh start then completes as in test 1.
//   5 start pulsed again at cycle 30 of a run -> ignored; done still at cycle 184.
//   6 SETTLE=3, model with 2-cycle result delay -> err_count=0.
//     done after 368 cycles.

Source files
------------

// File: rtl/addsub_bist.sv
// Self-test engine for a small add/subtract unit: sweeps operand vectors,
// checks each result against a built-in golden model and reports the outcome.
module addsub_bist #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned MAX_OP = 7,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [1:0]       select_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  input  logic [WIDTH-1:0] o_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       fail_sel,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_got
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int unsigned      CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_OP);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       select_nxt;
  logic [WIDTH-1:0] a_nxt, b_nxt;
  logic             busy_nxt, done_nxt, pass_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic             fail_valid_nxt;
  logic [1:0]       fail_sel_nxt;
  logic [WIDTH-1:0] fail_a_nxt, fail_b_nxt, fail_got_nxt;

  logic [WIDTH-1:0] expect_c;
  logic             mismatch_c;
  logic             last_vec_c;

  // Golden result from the registered operands; only add/sub are ever issued.
  always_comb begin
    expect_c   = select_o[0] ? (a_o - b_o) : (a_o + b_o);
    mismatch_c = (o_i != expect_c);
    last_vec_c = select_o[0] && (a_o == MAX_V) && (b_o == (MAX_V - WIDTH'(1)));
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      select_o   <= '0;
      a_o        <= '0;
      b_o        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_sel   <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_got   <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      select_o   <= select_nxt;
      a_o        <= a_nxt;
      b_o        <= b_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      err_count  <= err_nxt;
      fail_valid <= fail_valid_nxt;
      fail_sel   <= fail_sel_nxt;
      fail_a     <= fail_a_nxt;
      fail_b     <= fail_b_nxt;
      fail_got   <= fail_got_nxt;
    end
  end

  // Next-state, vector sequencing and result bookkeeping.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    select_nxt     = select_o;
    a_nxt          = a_o;
    b_nxt          = b_o;
    busy_nxt       = busy;
    done_nxt       = done;
    pass_nxt       = pass;
    err_nxt        = err_count;
    fail_valid_nxt = fail_valid;
    fail_sel_nxt   = fail_sel;
    fail_a_nxt     = fail_a;
    fail_b_nxt     = fail_b;
    fail_got_nxt   = fail_got;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt      = S_WAIT;
          cnt_nxt        = '0;
          select_nxt     = 2'b00;
          a_nxt          = '0;
          b_nxt          = '0;
          busy_nxt       = 1'b1;
          done_nxt       = 1'b0;
          pass_nxt       = 1'b0;
          err_nxt        = '0;
          fail_valid_nxt = 1'b0;
          fail_sel_nxt   = '0;
          fail_a_nxt     = '0;
          fail_b_nxt     = '0;
          fail_got_nxt   = '0;
        end
      end

      S_WAIT: begin
        if (cnt == CNT_LAST) begin
          state_nxt = S_CHECK;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      S_CHECK: begin
        if (mismatch_c) begin
          if (err_count != '1) begin
            err_nxt = err_count + ERR_W'(1);
          end
          if (!fail_valid) begin
            fail_valid_nxt = 1'b1;
            fail_sel_nxt   = select_o;
            fail_a_nxt     = a_o;
            fail_b_nxt     = b_o;
            fail_got_nxt   = o_i;
          end
        end

        if (last_vec_c) begin
          // Operands stay on the last vector while results are held.
          state_nxt = S_DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (err_nxt == '0);
        end else begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
          if (!select_o[0]) begin
            // Add phase: full square of operands, then switch to subtract.
            if (b_o == MAX_V) begin
              b_nxt = '0;
              if (a_o == MAX_V) begin
                select_nxt = 2'b01;
                a_nxt      = WIDTH'(1);
              end else begin
                a_nxt = a_o + WIDTH'(1);
              end
            end else begin
              b_nxt = b_o + WIDTH'(1);
            end
          end else begin
            // Subtract phase: b < a only, so no result underflows.
            if (b_o == (a_o - WIDTH'(1))) begin
              b_nxt = '0;
              a_nxt = a_o + WIDTH'(1);
            end else begin
              b_nxt = b_o + WIDTH'(1);
            end
          end
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_addsub_bist.sv
// Scoreboard bench for addsub_bist: a fault-injecting unit model drives o_i,
// a sweep-level reference predicts each run's report and a monitor checks it.
module tb_addsub_bist;

  typedef struct {
    int err;
    int pass;
    int fv;
    int fsel;
    int fa;
    int fb;
    int fgot;
    int lat;
    int start_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  // Fault model for unit 1: stuck-at-0 mask, stuck-at-1 mask, or add-only.
  logic [3:0] m_s0 = 4'h0;
  logic [3:0] m_s1 = 4'h0;
  bit         m_add = 1'b0;

  logic [1:0] sel1, fsel1, sel2, fsel2;
  logic [3:0] a1, b1, o1, fa1, fb1, fgot1;
  logic [3:0] a2, b2, o2, fa2, fb2, fgot2;
  logic [7:0] err1, err2;
  logic       busy1, done1, pass1, fv1;
  logic       busy2, done2, pass2, fv2;
  logic [3:0] p1, p2;

  exp_t q1[$];
  exp_t q2[$];
  exp_t m1e, m2e;
  bit   pd1 = 1'b0;
  bit   pd2 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] unit_out(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] s0, input logic [3:0] s1, input bit addonly);
    logic [3:0] r;
    r = (s[0] && !addonly) ? 4'(a - b) : 4'(a + b);
    return (r & ~s0) | s1;
  endfunction

  assign o1 = unit_out(sel1, a1, b1, m_s0, m_s1, m_add);

  // Unit 2 is ideal but its result lags the operands by two cycles.
  always @(posedge clk) begin
    p1 <= unit_out(sel2, a2, b2, 4'h0, 4'h0, 1'b0);
    p2 <= p1;
  end
  assign o2 = p2;

  addsub_bist dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .select_o(sel1), .a_o(a1), .b_o(b1), .o_i(o1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .fail_sel(fsel1), .fail_a(fa1), .fail_b(fb1), .fail_got(fgot1)
  );

  addsub_bist #(.SETTLE(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .select_o(sel2), .a_o(a2), .b_o(b2), .o_i(o2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_valid(fv2), .fail_sel(fsel2), .fail_a(fa2), .fail_b(fb2), .fail_got(fgot2)
  );

  task automatic chk(input string nm, input int got, input int exp_v);
    n_chk++;
    if (got != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp_v, cyc);
    end
  endtask

  // Reference: enumerate the sweep, apply the fault to each vector, tally the report.
  function automatic exp_t model(input int settle, input logic [3:0] s0, input logic [3:0] s1, input bit addonly);
    exp_t e;
    int   n;
    logic [3:0] got, want;
    e = '{err: 0, pass: 0, fv: 0, fsel: 0, fa: 0, fb: 0, fgot: 0, lat: 0, start_cyc: 0};
    n = 0;
    for (int s = 0; s < 2; s++) begin
      for (int a = s; a <= 7; a++) begin
        for (int b = 0; b <= ((s == 0) ? 7 : a - 1); b++) begin
          n++;
          want = (s == 0) ? 4'((a + b) % 16) : 4'((a - b + 16) % 16);
          got  = unit_out(2'(s), 4'(a), 4'(b), s0, s1, addonly);
          if (got != want) begin
            if (e.err < 255) e.err++;
            if (e.fv == 0) begin
              e.fv = 1; e.fsel = s; e.fa = a; e.fb = b; e.fgot = int'(got);
            end
          end
        end
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    e.lat  = n * (settle + 1);
    return e;
  endfunction

  task automatic check_report(input string tag, input exp_t e, input int busy, input int pass,
                              input int err, input int fv, input int fsel, input int fa, input int fb,
                              input int fgot, input int sel, input int a, input int b);
    chk({tag, ".latency"}, cyc - e.start_cyc, e.lat);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".err_count"}, err, e.err);
    chk({tag, ".pass"}, pass, e.pass);
    chk({tag, ".fail_valid"}, fv, e.fv);
    chk({tag, ".fail_sel"}, fsel, e.fsel);
    chk({tag, ".fail_a"}, fa, e.fa);
    chk({tag, ".fail_b"}, fb, e.fb);
    chk({tag, ".fail_got"}, fgot, e.fgot);
    chk({tag, ".last_vec"}, sel * 256 + a * 16 + b, 1 * 256 + 7 * 16 + 6);
  endtask

  // Monitors: on each rising done, pop the prediction and compare.
  always @(negedge clk) begin
    if (rst_n && done1 && !pd1) begin
      if (q1.size() == 0) chk("dut1.unexpected_done", 1, 0);
      else begin
        m1e = q1.pop_front();
        check_report("dut1", m1e, busy1, pass1, err1, fv1, fsel1, fa1, fb1, fgot1, sel1, a1, b1);
      end
    end
    pd1 = done1;
  end

  always @(negedge clk) begin
    if (rst_n && done2 && !pd2) begin
      if (q2.size() == 0) chk("dut2.unexpected_done", 1, 0);
      else begin
        m2e = q2.pop_front();
        check_report("dut2", m2e, busy2, pass2, err2, fv2, fsel2, fa2, fb2, fgot2, sel2, a2, b2);
      end
    end
    pd2 = done2;
  end

  // Pulse start on unit 1 and queue its predicted report.
  task automatic run1(input bit extra_pulse);
    exp_t e;
    e = model(1, m_s0, m_s1, m_add);
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    e.start_cyc = cyc;
    q1.push_back(e);
    if (extra_pulse) begin
      repeat (29) @(negedge clk);
      chk("dut1.busy_mid", busy1, 1);
      start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
    end
  endtask

  task automatic wait1();
    for (int i = 0; i < 3000 && q1.size() != 0; i++) @(negedge clk);
    chk("dut1.timeout_pending", q1.size(), 0);
    q1.delete();
  endtask

  task automatic chk_zero1(input string nm);
    chk(nm, int'({sel1, a1, b1, busy1, done1, pass1, err1, fv1, fsel1, fa1, fb1, fgot1}), 0);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero1("reset.dut1_outputs");
    chk("reset.dut2_outputs", int'({sel2, a2, b2, busy2, done2, pass2, err2, fv2, fsel2, fa2, fb2, fgot2}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero1("idle.dut1_no_start");

    // Ideal unit
    m_s0 = 4'h0; m_s1 = 4'h0; m_add = 1'b0;
    run1(1'b0); wait1();
    // Bit 0 stuck low
    m_s0 = 4'h1;
    run1(1'b0); wait1();
    // Unit always adds
    m_s0 = 4'h0; m_add = 1'b1;
    run1(1'b0); wait1();
    // Repeated start during a run is ignored
    m_add = 1'b0;
    run1(1'b1); wait1();

    // Reset mid-sweep aborts immediately
    run1(1'b0);
    repeat (49) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero1("abort.dut1_outputs");
    q1.delete();
    @(negedge clk) rst_n = 1'b1;
    run1(1'b0); wait1();

    // Random fault masks and idle gaps
    for (int k = 0; k < 5; k++) begin
      m_s0  = 4'($urandom_range(0, 15));
      m_s1  = 4'($urandom_range(0, 15)) & ~m_s0;
      if ($urandom_range(0, 2) == 0) m_s1 = 4'h0;
      m_add = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run1(1'b0); wait1();
    end

    // Longer settle against a unit with two cycles of latency
    e = model(3, 4'h0, 4'h0, 1'b0);
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    e.start_cyc = cyc;
    q2.push_back(e);
    for (int i = 0; i < 3000 && q2.size() != 0; i++) @(negedge clk);
    chk("dut2.timeout_pending", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
